axil_ctrl_slave: RTL and testbench

AXIL_CTRL_SLAVE -- requirements
Module: axil_ctrl_slave

---
 rtl/axil_ctrl_pkg.sv | 55 +++++
 rtl/axil_ctrl_slave.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_axil_ctrl_slave.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ctrl_pkg.sv
// rtl/axil_ctrl_pkg.sv - register map, response codes and FSM states for axil_ctrl_slave
package axil_ctrl_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_WR_ADDR = 8'h10;
  localparam logic [7:0] OFF_RD_ADDR = 8'h14;
  localparam logic [7:0] OFF_WDATA0  = 8'h18;
  localparam logic [7:0] OFF_WDATA1  = 8'h1C;
  localparam logic [7:0] OFF_WDATA2  = 8'h20;
  localparam logic [7:0] OFF_WDATA3  = 8'h24;
  localparam logic [7:0] OFF_RDATA0  = 8'h28;
  localparam logic [7:0] OFF_RDATA1  = 8'h2C;
  localparam logic [7:0] OFF_RDATA2  = 8'h30;
  localparam logic [7:0] OFF_RDATA3  = 8'h34;

  // Word indices: only addr[7:2] takes part in decode.
  localparam logic [5:0] IDX_CTRL    = OFF_CTRL[7:2];
  localparam logic [5:0] IDX_STATUS  = OFF_STATUS[7:2];
  localparam logic [5:0] IDX_WR_ADDR = OFF_WR_ADDR[7:2];
  localparam logic [5:0] IDX_RD_ADDR = OFF_RD_ADDR[7:2];
  localparam logic [5:0] IDX_WDATA0  = OFF_WDATA0[7:2];
  localparam logic [5:0] IDX_WDATA1  = OFF_WDATA1[7:2];
  localparam logic [5:0] IDX_WDATA2  = OFF_WDATA2[7:2];
  localparam logic [5:0] IDX_WDATA3  = OFF_WDATA3[7:2];
  localparam logic [5:0] IDX_RDATA0  = OFF_RDATA0[7:2];
  localparam logic [5:0] IDX_RDATA1  = OFF_RDATA1[7:2];
  localparam logic [5:0] IDX_RDATA2  = OFF_RDATA2[7:2];
  localparam logic [5:0] IDX_RDATA3  = OFF_RDATA3[7:2];

  localparam int unsigned STS_WR_DONE = 0;
  localparam int unsigned STS_RD_DONE = 1;
  localparam int unsigned STS_WR_BUSY = 2;
  localparam int unsigned STS_RD_BUSY = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic idx_mapped(input logic [5:0] idx);
    return (idx <= IDX_RDATA3) && (idx != 6'h02) && (idx != 6'h03);
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_ctrl_slave.sv
// rtl/axil_ctrl_slave.sv - AXI4-Lite control/status register block fronting an AXI master core
module axil_ctrl_slave
  import axil_ctrl_pkg::*;
(
  input  logic         aclk,
  input  logic         areset,
  input  logic [7:0]   s_axi_awaddr,
  input  logic         s_axi_awvalid,
  output logic         s_axi_awready,
  input  logic [31:0]  s_axi_wdata,
  input  logic [3:0]   s_axi_wstrb,
  input  logic         s_axi_wvalid,
  output logic         s_axi_wready,
  output logic [1:0]   s_axi_bresp,
  output logic         s_axi_bvalid,
  input  logic         s_axi_bready,
  input  logic [7:0]   s_axi_araddr,
  input  logic         s_axi_arvalid,
  output logic         s_axi_arready,
  output logic [31:0]  s_axi_rdata,
  output logic [1:0]   s_axi_rresp,
  output logic         s_axi_rvalid,
  input  logic         s_axi_rready,
  output logic         wr_start,
  output logic         rd_start,
  output logic [31:0]  wr_addr,
  output logic [31:0]  rd_addr,
  output logic [127:0] wr_data,
  input  logic         core_wr_done,
  input  logic         core_rd_done,
  input  logic [127:0] core_rd_data,
  output logic         wr_done,
  output logic         rd_done
);

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             ready_en_q, ready_en_d;
  logic             aw_vld_q, aw_vld_d;
  logic [5:0]       aw_idx_q, aw_idx_d;
  logic             w_vld_q, w_vld_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [3:0][31:0] wdata_q, wdata_d;
  logic [3:0][31:0] rdat_q, rdat_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_busy_q, wr_busy_d;
  logic             rd_busy_q, rd_busy_d;
  logic             wr_start_q, wr_start_d;
  logic             rd_start_q, rd_start_d;

  logic             aw_hs, w_hs, ar_hs;
  logic             reg_we;
  logic [5:0]       reg_idx;
  logic [31:0]      reg_wdata;
  logic [3:0]       reg_wstrb;
  logic             wr_go, rd_go;
  logic [31:0]      status_w;
  logic [31:0]      rd_mux;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ready_en_q keeps every ready low until the first edge after reset release.
  assign s_axi_awready = ready_en_q && (w_state_q == W_IDLE) && !aw_vld_q;
  assign s_axi_wready  = ready_en_q && (w_state_q == W_IDLE) && !w_vld_q;
  assign s_axi_arready = ready_en_q && (r_state_q == R_IDLE);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_start      = wr_start_q;
  assign rd_start      = rd_start_q;
  assign wr_addr       = wr_addr_q;
  assign rd_addr       = rd_addr_q;
  assign wr_data       = wdata_q;
  assign wr_done       = wr_done_q;
  assign rd_done       = rd_done_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Write channel: collect AW and W in either order, commit once both are present.
  always_comb begin
    w_state_d  = w_state_q;
    aw_vld_d   = aw_vld_q;
    aw_idx_d   = aw_idx_q;
    w_vld_d    = w_vld_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ready_en_d = 1'b1;
    reg_we     = 1'b0;
    reg_idx    = aw_vld_q ? aw_idx_q : s_axi_awaddr[7:2];
    reg_wdata  = w_vld_q ? w_data_q : s_axi_wdata;
    reg_wstrb  = w_vld_q ? w_strb_q : s_axi_wstrb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_vld_d = 1'b1;
          aw_idx_d = s_axi_awaddr[7:2];
        end
        if (w_hs) begin
          w_vld_d  = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
        end
        if ((aw_vld_q || aw_hs) && (w_vld_q || w_hs)) begin
          reg_we    = 1'b1;
          aw_vld_d  = 1'b0;
          w_vld_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = idx_mapped(reg_idx) ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register file, start/done bookkeeping and RDATA capture.
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wdata_d   = wdata_q;
    rdat_d    = rdat_q;
    wr_done_d = wr_done_q;
    rd_done_d = rd_done_q;
    wr_busy_d = wr_busy_q;
    rd_busy_d = rd_busy_q;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    if (reg_we) begin
      case (reg_idx)
        IDX_CTRL: begin
          wr_go = reg_wstrb[0] && reg_wdata[0];
          rd_go = reg_wstrb[0] && reg_wdata[1];
        end
        IDX_WR_ADDR: wr_addr_d  = merge_strb(wr_addr_q, reg_wdata, reg_wstrb);
        IDX_RD_ADDR: rd_addr_d  = merge_strb(rd_addr_q, reg_wdata, reg_wstrb);
        IDX_WDATA0:  wdata_d[0] = merge_strb(wdata_q[0], reg_wdata, reg_wstrb);
        IDX_WDATA1:  wdata_d[1] = merge_strb(wdata_q[1], reg_wdata, reg_wstrb);
        IDX_WDATA2:  wdata_d[2] = merge_strb(wdata_q[2], reg_wdata, reg_wstrb);
        IDX_WDATA3:  wdata_d[3] = merge_strb(wdata_q[3], reg_wdata, reg_wstrb);
        default: ;
      endcase
    end
    // A start is only accepted when idle, a done only when busy, so the two never collide.
    wr_start_d = wr_go && !wr_busy_q;
    rd_start_d = rd_go && !rd_busy_q;
    if (wr_start_d) begin
      wr_busy_d = 1'b1;
      wr_done_d = 1'b0;
    end
    if (rd_start_d) begin
      rd_busy_d = 1'b1;
      rd_done_d = 1'b0;
    end
    if (wr_busy_q && core_wr_done) begin
      wr_busy_d = 1'b0;
      wr_done_d = 1'b1;
    end
    if (rd_busy_q && core_rd_done) begin
      rd_busy_d = 1'b0;
      rd_done_d = 1'b1;
      rdat_d    = core_rd_data;
    end
  end

  always_comb begin
    status_w              = '0;
    status_w[STS_WR_DONE] = wr_done_q;
    status_w[STS_RD_DONE] = rd_done_q;
    status_w[STS_WR_BUSY] = wr_busy_q;
    status_w[STS_RD_BUSY] = rd_busy_q;
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[7:2])
      IDX_STATUS:  rd_mux = status_w;
      IDX_WR_ADDR: rd_mux = wr_addr_q;
      IDX_RD_ADDR: rd_mux = rd_addr_q;
      IDX_WDATA0:  rd_mux = wdata_q[0];
      IDX_WDATA1:  rd_mux = wdata_q[1];
      IDX_WDATA2:  rd_mux = wdata_q[2];
      IDX_WDATA3:  rd_mux = wdata_q[3];
      IDX_RDATA0:  rd_mux = rdat_q[0];
      IDX_RDATA1:  rd_mux = rdat_q[1];
      IDX_RDATA2:  rd_mux = rdat_q[2];
      IDX_RDATA3:  rd_mux = rdat_q[3];
      default:     rd_mux = '0;
    endcase
  end

  // Read channel samples register state before this cycle's write commits.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux;
          rresp_d   = idx_mapped(s_axi_araddr[7:2]) ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      ready_en_q <= 1'b0;
      aw_vld_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_vld_q    <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wdata_q    <= '0;
      rdat_q     <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      ready_en_q <= ready_en_d;
      aw_vld_q   <= aw_vld_d;
      aw_idx_q   <= aw_idx_d;
      w_vld_q    <= w_vld_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wdata_q    <= wdata_d;
      rdat_q     <= rdat_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      wr_busy_q  <= wr_busy_d;
      rd_busy_q  <= rd_busy_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_slave.sv
// tb/tb_axil_ctrl_slave.sv - directed plus randomized check of axil_ctrl_slave against a register-map model
module tb_axil_ctrl_slave;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [7:0]   s_axi_awaddr = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata = '0;
  logic [3:0]   s_axi_wstrb = '0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b0;
  logic [7:0]   s_axi_araddr = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;
  logic         wr_start, rd_start;
  logic [31:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;
  logic         core_wr_done = 1'b0;
  logic         core_rd_done = 1'b0;
  logic [127:0] core_rd_data = '0;
  logic         wr_done, rd_done;

  axil_ctrl_slave dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_start(wr_start), .rd_start(rd_start), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_data(wr_data), .core_wr_done(core_wr_done), .core_rd_done(core_rd_done),
    .core_rd_data(core_rd_data), .wr_done(wr_done), .rd_done(rd_done)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int exp_wr_pulses = 0;
  int exp_rd_pulses = 0;

  always @(negedge aclk) begin
    if (wr_start === 1'b1) wr_pulses <= wr_pulses + 1;
    if (rd_start === 1'b1) rd_pulses <= rd_pulses + 1;
  end

  // Reference model: the register map as plain variables.
  logic [31:0] m_wr_addr, m_rd_addr;
  logic [31:0] m_wdata [4];
  logic [31:0] m_rdata [4];
  bit m_wr_done, m_rd_done, m_wr_busy, m_rd_busy;

  function automatic void mdl_reset();
    m_wr_addr = 0; m_rd_addr = 0;
    for (int i = 0; i < 4; i++) begin m_wdata[i] = 0; m_rdata[i] = 0; end
    m_wr_done = 0; m_rd_done = 0; m_wr_busy = 0; m_rd_busy = 0;
  endfunction

  function automatic bit mapped(input logic [7:0] a);
    int off;
    off = int'({a[7:2], 2'b00});
    return off == 0 || off == 4 || (off >= 'h10 && off <= 'h34);
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int off;
    off = int'({a[7:2], 2'b00});
    if (off == 'h04) return {28'd0, m_rd_busy, m_wr_busy, m_rd_done, m_wr_done};
    if (off == 'h10) return m_wr_addr;
    if (off == 'h14) return m_rd_addr;
    if (off >= 'h18 && off <= 'h24) return m_wdata[(off - 'h18) / 4];
    if (off >= 'h28 && off <= 'h34) return m_rdata[(off - 'h28) / 4];
    return 32'd0;
  endfunction

  function automatic void mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int off;
    off = int'({a[7:2], 2'b00});
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (off == 'h10) m_wr_addr[8*b +: 8] = d[8*b +: 8];
        else if (off == 'h14) m_rd_addr[8*b +: 8] = d[8*b +: 8];
        else if (off >= 'h18 && off <= 'h24) m_wdata[(off - 'h18) / 4][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (off == 0 && s[0]) begin
      if (d[0] && !m_wr_busy) begin m_wr_busy = 1; m_wr_done = 0; exp_wr_pulses++; end
      if (d[1] && !m_rd_busy) begin m_rd_busy = 1; m_rd_done = 0; exp_rd_pulses++; end
    end
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // w_lead: cycles W is presented before AW; b_hold: cycles bready stays low once bvalid is up.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_hold, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] r0;
    @(posedge aclk); #1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_wvalid = 1'b1; s_axi_awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      cyc++;
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; s_axi_wvalid = 1'b0; end
      if (!aw_done && cyc >= w_lead) s_axi_awvalid = 1'b1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
    @(negedge aclk);
    chk("b_latency", s_axi_bvalid, 1'b1);
    r0 = s_axi_bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge aclk);
      chk("b_hold", {s_axi_bvalid, s_axi_bresp}, {1'b1, r0});
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    @(negedge aclk);
    chk("b_single", s_axi_bvalid, 1'b0);
    resp = r0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int r_hold,
                          output logic [31:0] d, output logic [1:0] resp);
    bit hs;
    int cyc;
    logic [31:0] d0;
    logic [1:0] r0;
    @(posedge aclk); #1;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge aclk);
      hs = s_axi_arready;
      @(posedge aclk); #1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    chk("ar_handshake", hs, 1'b1);
    @(negedge aclk);
    chk("r_latency", s_axi_rvalid, 1'b1);
    d0 = s_axi_rdata; r0 = s_axi_rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge aclk);
      chk("r_hold", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, r0, d0});
    end
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    @(negedge aclk);
    chk("r_single", s_axi_rvalid, 1'b0);
    d = d0; resp = r0;
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int w_lead, input int b_hold);
    logic [1:0] r;
    logic [1:0] er;
    er = mapped(a) ? 2'b00 : 2'b10;
    axi_write(a, d, s, w_lead, b_hold, r);
    mdl_write(a, d, s);
    chk(tag, r, er);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input int r_hold);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, r_hold, d, r);
    chk(tag, {r, d}, {(mapped(a) ? 2'b00 : 2'b10), exp_read(a)});
  endtask

  task automatic core_wr_pulse();
    @(posedge aclk); #1 core_wr_done = 1'b1;
    @(posedge aclk); #1 core_wr_done = 1'b0;
    if (m_wr_busy) begin m_wr_busy = 0; m_wr_done = 1; end
  endtask

  task automatic core_rd_pulse(input logic [127:0] d);
    @(posedge aclk); #1 core_rd_data = d; core_rd_done = 1'b1;
    @(posedge aclk); #1 core_rd_done = 1'b0;
    if (m_rd_busy) begin
      m_rd_busy = 0; m_rd_done = 1;
      for (int i = 0; i < 4; i++) m_rdata[i] = d[32*i +: 32];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] pat [4] = '{32'h01234567, 32'h89ABCDEF, 32'h76543210, 32'hFEDCBA98};
  logic [7:0]  rnd_offs [16] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20,
                                  8'h24, 8'h28, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h80, 8'hFC};

  initial begin
    logic [31:0] rd, old;
    logic [1:0]  br, rr;
    logic [7:0]  a;
    mdl_reset();

    idle(3);
    @(negedge aclk);
    chk("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, wr_start, rd_start, wr_done, rd_done}, 6'd0);
    chk("rst_regs", {wr_addr, rd_addr}, 64'd0);
    areset = 1'b0;
    #1 chk("ready_before_edge", s_axi_awready, 1'b0);
    @(negedge aclk);
    chk("ready_after_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    for (int i = 0; i < 4; i++) wr_chk("bresp_wdata", 8'(8'h18 + 4*i), pat[i], 4'hF, 0, 0);
    wr_chk("bresp_wr_addr", 8'h10, 32'hC0000000, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) rd_chk("readback_wdata", 8'(8'h18 + 4*i), 0);
    rd_chk("readback_wr_addr", 8'h10, 0);
    chk("wr_data_port", wr_data, 128'hFEDCBA98_76543210_89ABCDEF_01234567);
    chk("wr_addr_port", wr_addr, 32'hC0000000);

    wr_chk("strb_bresp", 8'h18, 32'hAAAA5555, 4'b0011, 0, 0);
    axi_read(8'h18, 0, rd, rr);
    chk("strb_merge", rd, 32'h01235555);
    wr_chk("strb_zero_bresp", 8'h1C, 32'h11111111, 4'b0000, 0, 0);
    axi_read(8'h0C, 0, rd, rr);
    chk("unmapped_read", {rr, rd}, {2'b10, 32'd0});
    wr_chk("unmapped_write", 8'h3C, 32'hDEADBEEF, 4'hF, 0, 0);
    wr_chk("status_write_ignored", 8'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
    for (int i = 0; i < 14; i++) rd_chk("sweep", 8'(4*i), 0);

    wr_chk("ctrl_wr_start", 8'h00, 32'h1, 4'hF, 0, 0);
    idle(2);
    chk("wr_start_once", wr_pulses, exp_wr_pulses);
    rd_chk("status_wr_busy", 8'h04, 0);
    wr_chk("ctrl_while_busy", 8'h00, 32'h1, 4'hF, 0, 0);
    idle(20);
    chk("wr_start_ignored", wr_pulses, exp_wr_pulses);
    core_wr_pulse();
    rd_chk("status_wr_done", 8'h04, 0);
    chk("wr_done_level", wr_done, 1'b1);

    wr_chk("ctrl_rd_start", 8'h00, 32'h2, 4'hF, 0, 0);
    idle(5);
    core_rd_pulse(128'hFEDCBA98_76543210_89ABCDEF_01234567);
    for (int i = 0; i < 4; i++) rd_chk("rdata_capture", 8'(8'h28 + 4*i), 0);
    rd_chk("status_rd_done", 8'h04, 0);
    chk("rd_done_level", rd_done, 1'b1);
    core_rd_pulse(128'h0BAD);
    rd_chk("rdata_idle_done", 8'h28, 0);

    wr_chk("ctrl_both", 8'h00, 32'h3, 4'hF, 0, 0);
    idle(2);
    chk("both_pulses", {wr_pulses, rd_pulses}, {exp_wr_pulses, exp_rd_pulses});
    rd_chk("status_both_busy", 8'h04, 0);
    core_wr_pulse();
    core_rd_pulse({$urandom, $urandom, $urandom, $urandom});
    rd_chk("status_both_done", 8'h04, 0);
    rd_chk("rdata3_both", 8'h34, 0);

    wr_chk("w_before_aw", 8'h14, 32'h13572468, 4'hF, 3, 4);
    rd_chk("r_held", 8'h14, 5);

    old = exp_read(8'h10);
    fork
      axi_write(8'h10, 32'h5A5A0001, 4'hF, 0, 1, br);
      axi_read(8'h10, 0, rd, rr);
    join
    chk("same_cycle_rw_old", {rr, rd}, {2'b00, old});
    mdl_write(8'h10, 32'h5A5A0001, 4'hF);
    rd_chk("same_cycle_rw_new", 8'h10, 0);

    for (int i = 0; i < 30; i++) begin
      a = rnd_offs[$urandom_range(0, 15)] | 8'($urandom_range(0, 3));
      wr_chk("rand_bresp", a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      a = 8'($urandom_range(0, 15) * 4) | 8'($urandom_range(0, 3));
      rd_chk("rand_read", a, $urandom_range(0, 2));
    end

    @(posedge aclk); #1;
    s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge aclk);
    chk("pre_reset_bvalid", {s_axi_bvalid, wr_addr}, {1'b1, 32'hCAFEF00D});
    #2 areset = 1'b1;
    #1;
    chk("async_reset_outs", {s_axi_bvalid, s_axi_awready, wr_done, rd_done}, 4'b0000);
    chk("async_reset_regs", {wr_addr, rd_addr, wr_data}, 192'd0);
    mdl_reset();
    @(negedge aclk);
    areset = 1'b0;
    wr_chk("post_reset_write", 8'h20, 32'h24681357, 4'hF, 0, 0);
    rd_chk("post_reset_read", 8'h20, 0);
    rd_chk("post_reset_status", 8'h04, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
